switch_input_ctrl: RTL and testbench

//  Parametrised successor to the 8-bit switch latch: synchronises and debounces a
//  SW_W-bit switch bank, flags changes, and returns a DATA_W-bit zero- or

---
 rtl/switch_pkg.sv | 28 ++
 rtl/sw_debounce.sv | 58 +++++
 rtl/switch_input_ctrl.sv | 71 +++++++
 tb/tb_switch_input_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Package : switch_pkg
// Brief   : Shared constants and word-extension helper for board I/O blocks.
// Rev     : 1.0
// ============================================================================
package switch_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;
  localparam int   EXT_MAX_W = 32;

  // Extends the low 'width' bits of value to 32 bits; callers size-cast the result.
  function automatic logic [EXT_MAX_W-1:0] ext_word(
    input logic [EXT_MAX_W-1:0] value,
    input logic [5:0]           width,
    input logic                 sext
  );
    logic [EXT_MAX_W-1:0] mask;
    mask = (width >= 6'd32) ? {EXT_MAX_W{1'b1}} : ((32'd1 << width) - 32'd1);
    if ((sext == EXT_SIGN) && (width != 6'd0) && value[width[4:0] - 5'd1])
      ext_word = value | ~mask;
    else
      ext_word = value & mask;
  endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module : sw_debounce
// Brief  : Two-flop synchroniser plus whole-vector stability counter.
// Rev    : 1.0
// ============================================================================
module sw_debounce #(
  parameter int W      = 8,
  parameter int DB_CNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] db_o,
  output logic         upd_o
);

  localparam int                CNT_W    = $clog2(DB_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CNT - 1);

  logic [W-1:0]     sync1_q, sync2_q, s_q, db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // s_q lags sync2 by one cycle so a one-cycle glitch never looks stable.
  assign upd_o = (sync2_q == s_q) && (sync2_q != db_q) && (cnt_q == CNT_LAST);
  assign db_o  = db_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if ((sync2_q != s_q) || (sync2_q == db_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      s_q     <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      s_q     <= sync2_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : sw_debounce
`default_nettype wire

// File: rtl/switch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : switch_input_ctrl
// Brief  : Debounced switch bank with extended read word and change flag.
// Rev    : 1.0
// ============================================================================
module switch_input_ctrl #(
  parameter int SW_W   = 8,
  parameter int DATA_W = 16,
  parameter int DB_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              rd_en,
  input  logic              sext,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              changed
);

  import switch_pkg::*;

  logic [SW_W-1:0]   db_w;
  logic              upd_w;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              changed_q, changed_d;

  sw_debounce #(
    .W      (SW_W),
    .DB_CNT (DB_CNT)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_i  (sw_in),
    .db_o  (db_w),
    .upd_o (upd_w)
  );

  always_comb begin
    rdata_d   = rdata_q;
    rvalid_d  = rd_en;
    changed_d = changed_q;
    if (rd_en) begin
      rdata_d   = DATA_W'(ext_word(EXT_MAX_W'(db_w), 6'(SW_W), sext));
      changed_d = 1'b0;
    end
    // A fresh update landing on a read edge must stay visible to the next reader.
    if (upd_w)
      changed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      changed_q <= changed_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign changed = changed_q;

endmodule : switch_input_ctrl
`default_nettype wire

// File: tb/tb_switch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_switch_input_ctrl
// Brief  : Directed bench for switch_input_ctrl (default and 16/16/1 builds).
// Rev    : 1.0
// ============================================================================
module tb_switch_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw_in;
  logic        rd_en, sext;
  logic [15:0] rdata;
  logic        rvalid, changed;

  logic [15:0] sw_in_b;
  logic        rd_en_b, sext_b;
  logic [15:0] rdata_b;
  logic        rvalid_b, changed_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_input_ctrl #(.SW_W(8), .DATA_W(16), .DB_CNT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .rd_en(rd_en), .sext(sext),
    .rdata(rdata), .rvalid(rvalid), .changed(changed)
  );

  switch_input_ctrl #(.SW_W(16), .DATA_W(16), .DB_CNT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in_b), .rd_en(rd_en_b), .sext(sext_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .changed(changed_b)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] rd, input logic rv, input logic ch);
    chk({tag, ".rdata"},   32'(rdata),   32'(rd));
    chk({tag, ".rvalid"},  32'(rvalid),  32'(rv));
    chk({tag, ".changed"}, 32'(changed), 32'(ch));
  endtask

  initial begin
    rst_n = 1'b1; sw_in = 8'hA5; rd_en = 1'b0; sext = 1'b0;
    sw_in_b = 16'h0000; rd_en_b = 1'b0; sext_b = 1'b0;

    // 1: reset, acquire A5, zero-extended read
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 16'h0000, 1'b0, 1'b0);
    chk("rst_b.rdata", 32'(rdata_b), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk_out("acq_a5", 16'h0000, 1'b0, 1'b1);
    rd_en = 1'b1; sext = 1'b0;
    tick();
    chk_out("read_a5", 16'h00A5, 1'b1, 1'b0);
    rd_en = 1'b0;
    tick();
    chk_out("read_a5_hold", 16'h00A5, 1'b0, 1'b0);

    // 2: step 00 -> 80, latency and extension
    sw_in = 8'h00;
    tick(10);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_out("settle_00", 16'h0000, 1'b1, 1'b0);
    tick();
    sw_in = 8'h80;
    tick(5);
    rd_en = 1'b1; sext = 1'b1;
    tick();
    chk_out("edge6_old", 16'h0000, 1'b1, 1'b0);
    rd_en = 1'b0;
    tick();
    chk_out("edge7_upd", 16'h0000, 1'b0, 1'b1);
    rd_en = 1'b1; sext = 1'b1;
    tick();
    chk_out("sext_80", 16'hFF80, 1'b1, 1'b0);
    sext = 1'b0;
    tick();
    chk_out("zext_80", 16'h0080, 1'b1, 1'b0);
    rd_en = 1'b0;
    tick();
    chk("rvalid_drop", 32'(rvalid), 32'h0);

    // 3: glitch and bounce never reach db
    sw_in = 8'h00;
    tick(10);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_out("back_00", 16'h0000, 1'b1, 1'b0);
    sw_in = 8'hFF;
    tick();
    sw_in = 8'h00;
    tick(12);
    chk("glitch.changed", 32'(changed), 32'h0);
    for (int i = 0; i < 8; i++) begin
      sw_in = i[0] ? 8'hF0 : 8'h0F;
      tick(2);
    end
    chk("bounce.changed", 32'(changed), 32'h0);
    sw_in = 8'h00;
    tick(10);
    chk("bounce_end.changed", 32'(changed), 32'h0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_out("bounce_read", 16'h0000, 1'b1, 1'b0);

    // 4: db update coincides with read
    sw_in = 8'h3C;
    tick(6);
    rd_en = 1'b1; sext = 1'b0;
    tick();
    chk_out("coincide", 16'h0000, 1'b1, 1'b1);
    tick();
    chk_out("after_coincide", 16'h003C, 1'b1, 1'b0);
    rd_en = 1'b0;
    tick();

    // 5: async reset mid-count and mid-read, then re-acquire
    sw_in = 8'h5A;
    tick(5);
    rd_en = 1'b1;
    tick();
    chk_out("pre_reset_read", 16'h003C, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("mid_reset", 16'h0000, 1'b0, 1'b0);
    rd_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(6);
    chk("reacq_e6.changed", 32'(changed), 32'h0);
    rd_en = 1'b1;
    tick();
    chk_out("reacq_e7", 16'h0000, 1'b1, 1'b1);
    tick();
    chk_out("reacq_read", 16'h005A, 1'b1, 1'b0);
    rd_en = 1'b0;
    tick();

    // 6: 16/16/1 build, 4-edge latency, no extension
    sw_in_b = 16'h8001;
    tick(3);
    chk("b_e3.changed", 32'(changed_b), 32'h0);
    tick();
    chk("b_e4.changed", 32'(changed_b), 32'h1);
    rd_en_b = 1'b1; sext_b = 1'b1;
    tick();
    chk("b_sext.rdata", 32'(rdata_b), 32'h8001);
    chk("b_sext.rvalid", 32'(rvalid_b), 32'h1);
    sext_b = 1'b0;
    tick();
    chk("b_zext.rdata", 32'(rdata_b), 32'h8001);
    chk("b_zext.changed", 32'(changed_b), 32'h0);
    rd_en_b = 1'b0;
    tick();
    chk("b_idle.rvalid", 32'(rvalid_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_switch_input_ctrl
`default_nettype wire
